rpn_stack_pop: RTL and testbench

Pop-and-execute engine for the RPN calculator. When an operator is requested, it reads the top two entries of the RAM operand stack: B is the top, at SP-1, and A is below it, at SP-2. It computes A op B and writes the result back at SP-2, then has the stack pointer register reload to SP-1. It is the reading side of the stack that the push controller fills: it shares the stack RAM port and the `STACK_POINTER` register, and the top level muxes control between the two controllers.

---
 rtl/rpn_pkg.sv | 31 +++
 rtl/rpn_alu8.sv | 27 ++
 rtl/rpn_stack_pop.sv | 102 ++++++++++
 tb/tb_rpn_stack_pop.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// rpn_pkg: shared operator codes, pop-engine state codes and display constants for the RPN calculator.
package rpn_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int MIN_OPERANDS = 2;

    typedef enum logic [3:0] {
        S_IDLE  = 4'h0,
        S_RD_B  = 4'h1,
        S_RD_A  = 4'h2,
        S_CAP_A = 4'h3,
        S_WRITE = 4'h4,
        S_DONE  = 4'h5,
        S_UFLOW = 4'h6
    } pop_state_t;

    // Active-low seven-segment patterns {g,f,e,d,c,b,a} for hex digits 0-F.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

endpackage

// File: rtl/rpn_alu8.sv
// rpn_alu8: combinational RPN operator unit, Y = A op B modulo 2^WIDTH.
module rpn_alu8
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] Y
);

    always_comb begin
        case (op)
            OP_ADD:  Y = A + B;
            OP_SUB:  Y = A - B;
            OP_AND:  Y = A & B;
            OP_OR:   Y = A | B;
            OP_XOR:  Y = A ^ B;
            OP_MUL:  Y = A * B;
            OP_SHL:  Y = A << B[2:0];
            OP_SHR:  Y = A >> B[2:0];
            default: Y = '0;
        endcase
    end

endmodule

// File: rtl/rpn_stack_pop.sv
// rpn_stack_pop: pops A (SP-2) and B (SP-1) from the stack RAM, writes A op B back at SP-2 and shrinks SP by one.
module rpn_stack_pop
    import rpn_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AW    = 8
) (
    input  logic             CLOCK_50,
    input  logic             KEY1_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    sp_in,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic [AW-1:0]    ram_addr,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_wdata,
    output logic [AW-1:0]    sp_out,
    output logic             sp_we,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] result
);

    pop_state_t       state, state_nx;
    logic [AW-1:0]    sp_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, y;

    rpn_alu8 #(.WIDTH(WIDTH)) u_alu (.A(a_q), .B(b_q), .op(op_q), .Y(y));

    always_ff @(posedge CLOCK_50) begin
        if (!KEY1_n) begin
            state  <= S_IDLE;
            sp_q   <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_IDLE && start) begin
                if (sp_in >= AW'(MIN_OPERANDS)) begin
                    sp_q <= sp_in;
                    op_q <= op;
                    err  <= 1'b0;
                end else begin
                    err  <= 1'b1;
                end
            end
            // Synchronous RAM: data for the address driven last cycle arrives now.
            if (state == S_RD_A)  b_q    <= ram_rdata;
            if (state == S_CAP_A) a_q    <= ram_rdata;
            if (state == S_WRITE) result <= y;
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        sp_out    = '0;
        sp_we     = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nx = (sp_in >= AW'(MIN_OPERANDS)) ? S_RD_B : S_UFLOW;
            S_RD_B: begin
                busy     = 1'b1;
                ram_addr = sp_q - AW'(1);
                state_nx = S_RD_A;
            end
            S_RD_A: begin
                busy     = 1'b1;
                ram_addr = sp_q - AW'(2);
                state_nx = S_CAP_A;
            end
            S_CAP_A: begin
                busy     = 1'b1;
                ram_addr = sp_q - AW'(2);
                state_nx = S_WRITE;
            end
            S_WRITE: begin
                busy      = 1'b1;
                ram_addr  = sp_q - AW'(2);
                ram_wdata = y;
                ram_we    = 1'b1;
                sp_out    = sp_q - AW'(1);
                sp_we     = 1'b1;
                state_nx  = S_DONE;
            end
            S_DONE, S_UFLOW: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rpn_stack_pop.sv
// tb_rpn_stack_pop: randomized and directed checks of the pop engine against a behavioural stack-RAM model.
module tb_rpn_stack_pop;

    logic       CLOCK_50 = 1'b0;
    logic       KEY1_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] op = 3'd0;
    logic [7:0] sp_in = 8'd0;
    logic [7:0] ram_rdata = 8'd0;
    logic [7:0] ram_addr, ram_wdata, sp_out, result;
    logic       ram_we, sp_we, busy, done, err;

    logic [7:0] mem [256];
    int vectors = 0;
    int miscompares = 0;

    rpn_stack_pop #(.WIDTH(8), .AW(8)) dut (
        .CLOCK_50(CLOCK_50), .KEY1_n(KEY1_n), .start(start), .op(op), .sp_in(sp_in),
        .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .sp_out(sp_out), .sp_we(sp_we), .busy(busy), .done(done), .err(err), .result(result)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Stack RAM: synchronous read with one cycle of latency.
    always @(posedge CLOCK_50) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    function automatic logic [7:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o);
        int r;
        case (o)
            3'd0: r = int'(a) + int'(b);
            3'd1: r = int'(a) - int'(b);
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = int'(a) * int'(b);
            3'd6: r = int'(a) * (1 << (b % 8));
            default: r = int'(a) / (1 << (b % 8));
        endcase
        return r[7:0];
    endfunction

    task automatic test_reset();
        KEY1_n = 1'b0; start = 1'b1; op = 3'd5; sp_in = 8'd9;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        vectors++;
        if ({busy, done, err, ram_we, sp_we, ram_addr, ram_wdata, sp_out, result} !== 37'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b we=%b spwe=%b addr=%h wdata=%h sp_out=%h result=%h, want all 0",
                     busy, done, err, ram_we, sp_we, ram_addr, ram_wdata, sp_out, result);
        end
        start = 1'b0; KEY1_n = 1'b1;
        @(negedge CLOCK_50);
        vectors++;
        if ({busy, done, ram_we, sp_we} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_idle: got flags %b, want 0000", {busy, done, ram_we, sp_we});
        end
    endtask

    // One full operator sequence; with hold, start keeps toggling and op/sp_in change after capture.
    task automatic run_op(input logic [2:0] o, input logic [7:0] sp, input bit hold);
        logic [7:0] ey;
        logic [3:0] flags;
        int writes;
        ey = ref_alu(mem[sp - 8'd2], mem[sp - 8'd1], o);
        writes = 0;
        @(negedge CLOCK_50);
        start = 1'b1; op = o; sp_in = sp;
        for (int c = 1; c <= 6; c++) begin
            @(negedge CLOCK_50);
            flags = {c <= 4, c == 5, c == 4, c == 4};
            vectors++;
            if ({busy, done, ram_we, sp_we} !== flags) begin
                miscompares++;
                $display("FAIL seq_flags op=%0d sp=%0d cycle %0d: got busy/done/we/spwe=%b, want %b",
                         o, sp, c, {busy, done, ram_we, sp_we}, flags);
            end
            if (ram_we) writes++;
            if (c == 1) begin
                vectors++;
                if (err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL err_clear: got err=%b, want 0", err);
                end
            end
            if (c == 4) begin
                vectors++;
                if ({ram_addr, ram_wdata, sp_out} !== {sp - 8'd2, ey, sp - 8'd1}) begin
                    miscompares++;
                    $display("FAIL write_cycle op=%0d sp=%0d: got addr=%h wdata=%h sp_out=%h, want addr=%h wdata=%h sp_out=%h",
                             o, sp, ram_addr, ram_wdata, sp_out, sp - 8'd2, ey, sp - 8'd1);
                end
            end
            if (c == 5) begin
                vectors++;
                if (result !== ey) begin
                    miscompares++;
                    $display("FAIL result op=%0d: got %h, want %h", o, result, ey);
                end
            end
            if (hold) begin
                start = (c <= 4);
                op = ~o;
                sp_in = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        vectors++;
        if (writes != 1) begin
            miscompares++;
            $display("FAIL write_count op=%0d: got %0d writes, want 1", o, writes);
        end
    endtask

    task automatic test_add();
        mem[0] = 8'd3; mem[1] = 8'd5;
        run_op(3'd0, 8'd2, 1'b0);
        vectors++;
        if (result !== 8'd8 || mem[0] !== 8'd8) begin
            miscompares++;
            $display("FAIL add_directed: got result=%h mem0=%h, want 08", result, mem[0]);
        end
    endtask

    task automatic test_sub_shl();
        mem[4] = 8'd5; mem[5] = 8'd7;
        run_op(3'd1, 8'd6, 1'b0);
        vectors++;
        if (mem[4] !== 8'hFE) begin
            miscompares++;
            $display("FAIL sub_directed: got mem4=%h, want fe", mem[4]);
        end
        mem[4] = 8'h81; mem[5] = 8'd1;
        run_op(3'd6, 8'd6, 1'b0);
        vectors++;
        if (mem[4] !== 8'h02) begin
            miscompares++;
            $display("FAIL shl_directed: got mem4=%h, want 02", mem[4]);
        end
    endtask

    task automatic test_underflow(input logic [7:0] sp);
        @(negedge CLOCK_50);
        start = 1'b1; sp_in = sp; op = 3'($urandom);
        @(negedge CLOCK_50);
        start = 1'b0;
        vectors++;
        if ({busy, done, ram_we, sp_we, err} !== 5'b01001) begin
            miscompares++;
            $display("FAIL uflow_cycle1 sp=%0d: got busy/done/we/spwe/err=%b, want 01001", sp, {busy, done, ram_we, sp_we, err});
        end
        @(negedge CLOCK_50);
        vectors++;
        if ({busy, done, ram_we, sp_we, err} !== 5'b00001) begin
            miscompares++;
            $display("FAIL uflow_after sp=%0d: got busy/done/we/spwe/err=%b, want 00001", sp, {busy, done, ram_we, sp_we, err});
        end
    endtask

    task automatic test_back_to_back();
        mem[20] = 8'h3C; mem[21] = 8'h0F;
        run_op(3'd2, 8'd22, 1'b1);
        vectors++;
        if (mem[20] !== 8'h0C) begin
            miscompares++;
            $display("FAIL hold_and: got mem20=%h, want 0c", mem[20]);
        end
        mem[253] = 8'h12; mem[254] = 8'h34;
        run_op(3'd4, 8'd255, 1'b1);
    endtask

    task automatic test_reset_mid();
        int strobes;
        strobes = 0;
        mem[10] = 8'd6; mem[11] = 8'd7;
        @(negedge CLOCK_50);
        start = 1'b1; op = 3'd5; sp_in = 8'd12;
        @(negedge CLOCK_50);
        start = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        KEY1_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLOCK_50);
            if (ram_we || sp_we) strobes++;
            if (c == 1) KEY1_n = 1'b1;
        end
        vectors++;
        if (strobes != 0 || result !== 8'd0 || mem[10] !== 8'd6 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got strobes=%0d result=%h mem10=%h busy=%b, want 0 00 06 0", strobes, result, mem[10], busy);
        end
        run_op(3'd5, 8'd12, 1'b0);
        vectors++;
        if (mem[10] !== 8'd42) begin
            miscompares++;
            $display("FAIL mul_after_reset: got mem10=%h, want 2a", mem[10]);
        end
    endtask

    task automatic test_random();
        logic [7:0] sp;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                test_underflow(8'($urandom_range(0, 1)));
            end else begin
                sp = 8'($urandom_range(2, 255));
                mem[sp - 8'd1] = 8'($urandom);
                mem[sp - 8'd2] = 8'($urandom);
                run_op(3'($urandom), sp, 1'($urandom));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        test_reset();
        test_add();
        test_sub_shl();
        test_underflow(8'd1);
        test_underflow(8'd0);
        run_op(3'd3, 8'd2, 1'b0);
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
